// File: rtl/muldiv_unit_pkg.sv
// Shared M-extension encodings and operand-signedness helpers for the
// iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam int FUNCT3_W = 3;

    localparam logic [FUNCT3_W-1:0] FUNCT3_MUL    = 3'b000;
    localparam logic [FUNCT3_W-1:0] FUNCT3_MULH   = 3'b001;
    localparam logic [FUNCT3_W-1:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [FUNCT3_W-1:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [FUNCT3_W-1:0] FUNCT3_DIV    = 3'b100;
    localparam logic [FUNCT3_W-1:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [FUNCT3_W-1:0] FUNCT3_REM    = 3'b110;
    localparam logic [FUNCT3_W-1:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_div(input logic [FUNCT3_W-1:0] f);
        return f[2];
    endfunction

    function automatic logic is_rem(input logic [FUNCT3_W-1:0] f);
        return f[2] & f[1];
    endfunction

    function automatic logic rs1_signed(input logic [FUNCT3_W-1:0] f);
        return f inside {FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_DIV, FUNCT3_REM};
    endfunction

    function automatic logic rs2_signed(input logic [FUNCT3_W-1:0] f);
        return f inside {FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                start;
    logic [FUNCT3_W-1:0] funct3;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic                flush;
    logic                busy;
    logic                done;
    logic [XLEN-1:0]     result;

    modport master (output start, funct3, rs1, rs2, flush, input busy, done, result);
    modport slave  (input start, funct3, rs1, rs2, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign restored when entering DONE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6     // 2**CNT_W must exceed XLEN
) (
    input logic          clock,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

    md_state_e           state, state_nxt;
    logic [FUNCT3_W-1:0] op;
    logic                neg_res;
    logic [2*XLEN-1:0]   acc;      // mul: {partial product, multiplier}; div: low half = dividend/quotient
    logic [XLEN:0]       rem;
    logic [XLEN-1:0]     opb;      // multiplicand or divisor magnitude
    logic [CNT_W-1:0]    cnt;
    logic                busy, done;
    logic [XLEN-1:0]     result;

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic            accept, sign_a, sign_b, div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    always_comb begin
        accept   = (state == MD_IDLE) && bus.start && !bus.flush;
        sign_a   = rs1_signed(bus.funct3) && bus.rs1[XLEN-1];
        sign_b   = rs2_signed(bus.funct3) && bus.rs2[XLEN-1];
        abs_a    = mag(bus.rs1, sign_a);
        abs_b    = mag(bus.rs2, sign_b);
        div_zero = (bus.rs2 == '0);
        div_ovf  = (bus.funct3 == FUNCT3_DIV || bus.funct3 == FUNCT3_REM) &&
                   (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);
        special  = is_div(bus.funct3) && (div_zero || div_ovf);
        special_res = '0;
        case (bus.funct3)
            FUNCT3_DIV, FUNCT3_DIVU: special_res = div_zero ? '1 : MIN_NEG;
            FUNCT3_REM, FUNCT3_REMU: special_res = div_zero ? bus.rs1 : '0;
            default:                 special_res = '0;
        endcase
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt, prod;
    logic [XLEN+1:0]   div_trial, div_diff;
    logic              q_bit;
    logic [XLEN:0]     rem_nxt;
    logic [XLEN-1:0]   quo_nxt, fin_res;

    // Final-iteration values feed the result directly so it lands with done.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt   = {mul_sum, acc[XLEN-1:1]};
        prod      = neg_res ? -mul_nxt : mul_nxt;
        div_trial = {rem, acc[XLEN-1]};
        div_diff  = div_trial - {2'b00, opb};
        q_bit     = !div_diff[XLEN+1];
        rem_nxt   = q_bit ? div_diff[XLEN:0] : div_trial[XLEN:0];
        quo_nxt   = {acc[XLEN-2:0], q_bit};
        fin_res   = '0;
        case (op)
            FUNCT3_MUL:                              fin_res = prod[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: fin_res = prod[2*XLEN-1:XLEN];
            FUNCT3_DIV, FUNCT3_DIVU:                 fin_res = mag(quo_nxt, neg_res);
            FUNCT3_REM, FUNCT3_REMU:                 fin_res = mag(rem_nxt[XLEN-1:0], neg_res);
            default:                                 fin_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = special ? MD_DONE : MD_RUN;
            MD_RUN:  if (cnt == LAST) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
        if (bus.flush) state_nxt = MD_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= MD_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            op      <= '0;
            neg_res <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            opb     <= '0;
            cnt     <= '0;
        end else begin
            busy <= (state_nxt != MD_IDLE);
            done <= (state_nxt == MD_DONE);
            case (state)
                MD_IDLE: if (accept) begin
                    op      <= bus.funct3;
                    neg_res <= is_rem(bus.funct3) ? sign_a : (sign_a ^ sign_b);
                    acc     <= {{XLEN{1'b0}}, is_div(bus.funct3) ? abs_a : abs_b};
                    opb     <= is_div(bus.funct3) ? abs_b : abs_a;
                    rem     <= '0;
                    cnt     <= '0;
                    if (special) result <= special_res;
                end
                MD_RUN: if (!bus.flush) begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div(op)) begin
                        acc[XLEN-1:0] <= quo_nxt;
                        rem           <= rem_nxt;
                    end else begin
                        acc <= mul_nxt;
                    end
                    if (cnt == LAST) result <= fin_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0]  ea, eb;
        logic signed [131:0] p;
        int   sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ea  = {{34{(f == FUNCT3_MULH || f == FUNCT3_MULHSU) && a[31]}}, a};
        eb  = {{34{(f == FUNCT3_MULH) && b[31]}}, b};
        p   = ea * eb;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            FUNCT3_MUL: return p[31:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: return p[63:32];
            FUNCT3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            FUNCT3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            FUNCT3_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            FUNCT3_REMU: begin
                if (b == 0) return a;
                return a % b;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (f == FUNCT3_DIV || f == FUNCT3_REM) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return (f[2] && (b == 0 || ovf)) ? 1 : LAT;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        int lat, done_at, pulses;
        logic busy_ok;
        logic [31:0] got;
        lat = ref_lat(f, a, b);
        done_at = 0; pulses = 0; busy_ok = 1'b1; got = '0;
        @(negedge clock);
        bus.start = 1'b1; bus.funct3 = f; bus.rs1 = a; bus.rs2 = b;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                pulses++;
                if (done_at == 0) done_at = k;
                got = bus.result;
            end
            if (bus.busy !== (k <= lat)) busy_ok = 1'b0;
            if (k == 1) begin
                bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.rs1 = $urandom; bus.rs2 = $urandom;
            end
        end
        total++; if (done_at != lat) $display("FAIL %s latency: got %0d want %0d", name, done_at, lat); else passed++;
        total++; if (pulses != 1) $display("FAIL %s done pulses: got %0d want 1", name, pulses); else passed++;
        total++; if (!busy_ok) $display("FAIL %s busy window: got off-window busy, want high T+1..T+%0d", name, lat); else passed++;
        total++; if (got !== exp) $display("FAIL %s result: got %h want %h", name, got, exp); else passed++;
        total++; if (bus.result !== exp) $display("FAIL %s result hold: got %h want %h", name, bus.result, exp); else passed++;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b want 0", bus.done); else passed++;
        total++; if (bus.result !== 32'h0) $display("FAIL reset result: got %h want 0", bus.result); else passed++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        do_op(FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        do_op(FUNCT3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min");
        do_op(FUNCT3_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulhu_min");
        do_op(FUNCT3_MULHSU, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, "mulhsu_min");
        do_op(FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_-7/2");
        do_op(FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_-7/2");
        do_op(FUNCT3_DIVU,   32'd100,        32'd7,         32'd14,        "divu_100/7");
        do_op(FUNCT3_REMU,   32'd100,        32'd7,         32'd2,         "remu_100/7");
        do_op(FUNCT3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by0");
        do_op(FUNCT3_REM,    32'd5,          32'd0,         32'd5,         "rem_by0");
        do_op(FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "rem_ovf");
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 25; i++) begin
            f = 3'($urandom_range(0, 7));
            a = rand_opnd();
            b = rand_opnd();
            do_op(f, a, b, ref_md(f, a, b), "random");
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] exp, got;
        int done_at, pulses;
        exp = ref_md(FUNCT3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        done_at = 0; pulses = 0; got = '0;
        @(negedge clock);
        bus.start = 1'b1; bus.funct3 = FUNCT3_MULHU; bus.rs1 = 32'hDEAD_BEEF; bus.rs2 = 32'h1234_5678;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin pulses++; if (done_at == 0) done_at = k; got = bus.result; end
            bus.start = (k == 10);
            if (k == 10) begin bus.funct3 = FUNCT3_DIVU; bus.rs1 = 32'd9; bus.rs2 = 32'd0; end
        end
        total++; if (done_at != LAT) $display("FAIL ignore_start latency: got %0d want %0d", done_at, LAT); else passed++;
        total++; if (pulses != 1) $display("FAIL ignore_start pulses: got %0d want 1", pulses); else passed++;
        total++; if (got !== exp) $display("FAIL ignore_start result: got %h want %h", got, exp); else passed++;
    endtask

    task automatic test_flush();
        logic [31:0] prior;
        int pulses;
        logic busy_late;
        prior = ref_md(FUNCT3_MUL, 32'd1234, 32'd5678);
        do_op(FUNCT3_MUL, 32'd1234, 32'd5678, prior, "flush_setup");
        pulses = 0; busy_late = 1'b0;
        @(negedge clock);
        bus.start = 1'b1; bus.funct3 = FUNCT3_DIV; bus.rs1 = 32'd1000; bus.rs2 = 32'd7;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) pulses++;
            if (k == 5) begin
                total++; if (bus.busy !== 1'b1) $display("FAIL flush pre busy: got %b want 1", bus.busy); else passed++;
            end
            if (k == 6) begin
                total++; if (bus.busy !== 1'b0) $display("FAIL flush busy drop: got %b want 0", bus.busy); else passed++;
            end
            if (k > 6 && bus.busy !== 1'b0) busy_late = 1'b1;
            bus.start = 1'b0;
            bus.flush = (k == 5);
        end
        total++; if (pulses != 0) $display("FAIL flush done: got %0d pulses want 0", pulses); else passed++;
        total++; if (busy_late) $display("FAIL flush busy after: got 1 want 0"); else passed++;
        total++; if (bus.result !== prior) $display("FAIL flush result kept: got %h want %h", bus.result, prior); else passed++;
    endtask

    task automatic test_flush_start();
        logic [31:0] prior;
        int pulses, busy_cnt;
        prior = bus.result;
        pulses = 0; busy_cnt = 0;
        @(negedge clock);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = FUNCT3_DIVU; bus.rs1 = 32'd77; bus.rs2 = 32'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) pulses++;
            if (bus.busy === 1'b1) busy_cnt++;
            bus.start = 1'b0; bus.flush = 1'b0;
        end
        total++; if (busy_cnt != 0) $display("FAIL flush_start busy: got %0d cycles want 0", busy_cnt); else passed++;
        total++; if (pulses != 0) $display("FAIL flush_start done: got %0d want 0", pulses); else passed++;
        total++; if (bus.result !== prior) $display("FAIL flush_start result: got %h want %h", bus.result, prior); else passed++;
    endtask

    task automatic test_flush_done();
        logic [31:0] prior;
        int pulses;
        prior = bus.result;
        pulses = 0;
        @(negedge clock);
        bus.start = 1'b1; bus.funct3 = FUNCT3_MUL; bus.rs1 = 32'd11; bus.rs2 = 32'd13;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) pulses++;
            if (k == LAT) begin
                total++; if (bus.busy !== 1'b0) $display("FAIL flush_done busy: got %b want 0", bus.busy); else passed++;
            end
            bus.start = 1'b0;
            bus.flush = (k == LAT - 1);
        end
        total++; if (pulses != 0) $display("FAIL flush_done done: got %0d want 0", pulses); else passed++;
        total++; if (bus.result !== prior) $display("FAIL flush_done result: got %h want %h", bus.result, prior); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a, exp_b, got_a, got_b;
        int at_a, at_b, pulses;
        logic busy_ok;
        exp_a = ref_md(FUNCT3_REMU, 32'hCAFE_F00D, 32'd1000);
        exp_b = ref_md(FUNCT3_MULH, 32'hFFFF_FF00, 32'h0001_0001);
        at_a = 0; at_b = 0; pulses = 0; busy_ok = 1'b1; got_a = '0; got_b = '0;
        @(negedge clock);
        bus.start = 1'b1; bus.funct3 = FUNCT3_REMU; bus.rs1 = 32'hCAFE_F00D; bus.rs2 = 32'd1000;
        for (int k = 1; k <= 2 * LAT + 5; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                pulses++;
                if (at_a == 0) begin at_a = k; got_a = bus.result; end
                else begin at_b = k; got_b = bus.result; end
            end
            if (bus.busy !== ((k <= LAT) || (k >= LAT + 2 && k <= 2 * LAT + 1))) busy_ok = 1'b0;
            if (k == LAT + 1) begin
                bus.funct3 = FUNCT3_MULH; bus.rs1 = 32'hFFFF_FF00; bus.rs2 = 32'h0001_0001;
            end
            if (k == LAT + 2) bus.start = 1'b0;
        end
        total++; if (at_a != LAT) $display("FAIL b2b first latency: got %0d want %0d", at_a, LAT); else passed++;
        total++; if (at_b != 2 * LAT + 1) $display("FAIL b2b second latency: got %0d want %0d", at_b, 2 * LAT + 1); else passed++;
        total++; if (pulses != 2) $display("FAIL b2b pulses: got %0d want 2", pulses); else passed++;
        total++; if (!busy_ok) $display("FAIL b2b busy window: got off-window busy, want gap at T+%0d", LAT + 1); else passed++;
        total++; if (got_a !== exp_a) $display("FAIL b2b first result: got %h want %h", got_a, exp_a); else passed++;
        total++; if (got_b !== exp_b) $display("FAIL b2b second result: got %h want %h", got_b, exp_b); else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        bus.start = 1'b1; bus.funct3 = FUNCT3_DIV; bus.rs1 = 32'hFFFF_0000; bus.rs2 = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (19) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_mid busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_mid done: got %b want 0", bus.done); else passed++;
        total++; if (bus.result !== 32'h0) $display("FAIL reset_mid result: got %h want 0", bus.result); else passed++;
        @(negedge clock);
        reset = 1'b1;
        do_op(FUNCT3_MUL, 32'd3, 32'd4, 32'd12, "post_reset_mul");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_flush();
        test_flush_start();
        test_flush_done();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage. It executes the multi-cycle ops that the ALU control decoder marks for FUNCT7_MUL.
- Takes rs1/rs2 and the M-extension funct3, runs a shift-add multiply or a restoring divide over XLEN cycles, and returns a one-cycle done pulse with the result.
- The pipeline holds EX stalled while busy is high.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A (dividend/multiplicand).
- rs2  in  XLEN  operand B (divisor/multiplier).
- flush  in  1  pipeline kill; aborts current op.
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
- done  out  1  one-cycle result-valid pulse.
- result  out  XLEN  result; held stable until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0. Reset mid-operation abandons the op; no done is produced.
- States:
  - IDLE: on start=1 and flush=0, latch op, signs and |operands|, then go to RUN, or to DONE for a special case.
  - RUN: one iteration per cycle; counter goes 0..XLEN-1; on the last iteration go to DONE.
  - DONE: done=1, result written, then return to IDLE.
- Latency: start sampled at cycle T; RUN covers T+1..T+XLEN; done=1 at T+XLEN+1 (T+33 for XLEN=32). Back-to-back start is accepted at T+XLEN+2 at the earliest.
- start while not IDLE is ignored. funct3/rs1/rs2 are captured only at acceptance; later changes have no effect.
- Signedness:
  - MULH, DIV and REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
  - MUL uses the low half, which is sign-independent.
- Arithmetic: the core works on unsigned magnitudes. The final two's-complement negate is applied in the DONE transition.
  - Product sign = sA^sB.
  - Quotient sign = sA^sB.
  - Remainder sign = sA.
- Multiply:
  - 2*XLEN accumulator; each RUN cycle adds the multiplicand when the multiplier LSB is 1, then shifts right.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits of the sign-corrected 2*XLEN product.
- Divide: restoring, one quotient bit per cycle, MSB first, with an XLEN+1-bit partial remainder.
- Special cases resolve in IDLE with no RUN phase, so done=1 at T+1:
  - Divisor=0: DIV/DIVU give all-ones (0xFFFFFFFF); REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF) on DIV: 0x80000000. On REM: 0.
- flush=1 in any state: next state IDLE, busy=0, done=0, result unchanged.
- flush and start in the same IDLE cycle: flush wins and the start is dropped.
- flush in the DONE cycle: done is suppressed in that cycle.
- busy and done are registered outputs, with no combinational path from inputs.

Decomposition:
- Add FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU, FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM and FUNCT3_REMU to constants.vh, alongside the existing FUNCT7_MUL.
- Add state encodings MD_IDLE, MD_RUN and MD_DONE to constants.vh.
- Single module; no sub-module. The magnitude/negate logic is a local function.

Test Plan:
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD) -> done at T+33, result=0xFFFFFFEB; busy high T+1..T+33.
- MULH/MULHU/MULHSU: rs1=0x80000000, rs2=0x80000000 -> MULH 0x40000000; MULHU 0x40000000; MULHSU 0xC0000000.
- DIV/REM: rs1=-7, rs2=2 -> DIV 0xFFFFFFFD (-3); REM 0xFFFFFFFF (-1). DIVU with rs1=100, rs2=7 -> 14; REMU with the same operands -> 2.
- Divide by zero: DIVU rs1=5, rs2=0 -> done at T+1, result 0xFFFFFFFF. REM rs1=5, rs2=0 -> 5. DIV overflow (0x80000000 / 0xFFFFFFFF) -> 0x80000000 at T+1.
- Handshake: start pulsed again at T+10 during RUN -> ignored, single done at T+33. flush at T+5 -> busy=0 at T+6, no done, prior result retained.
- Reset: assert reset low asynchronously at T+20 of a DIV -> all outputs 0 immediately. After release, a new MUL 3*4 -> result 12 with correct latency.
